// File: rtl/pkt_hdr_pkg.sv
// Shared definitions for the packet header capture path: PHV layout,
// stream geometry, capture FSM states and the tkeep popcount helper.
package pkt_hdr_pkg;

   localparam int unsigned C_S_AXIS_DATA_WIDTH = 256;
   localparam int unsigned KEEP_WIDTH          = C_S_AXIS_DATA_WIDTH / 8;
   localparam int unsigned HDR_BEATS           = 4;
   localparam int unsigned HDR_WIDTH           = C_S_AXIS_DATA_WIDTH * HDR_BEATS;
   localparam int unsigned LEN_WIDTH           = 8;
   localparam int unsigned RSVD_WIDTH          = 704;
   localparam int unsigned PHV_WIDTH           = RSVD_WIDTH + LEN_WIDTH + HDR_WIDTH;

   // PHV field offsets
   localparam int unsigned RSVD_POS = 0;
   localparam int unsigned LEN_POS  = 704;
   localparam int unsigned HDR_POS  = 712;

   // Per-beat byte count: 0..32 needs 6 bits
   localparam int unsigned POPCNT_WIDTH = 6;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      SKIP    = 2'd2
   } cap_state_e;

   function automatic logic [POPCNT_WIDTH-1:0] popcount32(input logic [31:0] keep);
      logic [POPCNT_WIDTH-1:0] cnt;
      cnt = '0;
      for (int i = 0; i < 32; i++) begin
         cnt = cnt + POPCNT_WIDTH'(keep[i]);
      end
      return cnt;
   endfunction

endpackage

// File: rtl/pkt_hdr_keep_mask.sv
// Expands a byte-enable vector into a per-bit data mask and counts the
// enabled bytes. Purely combinational; shared with the reassembly stage.
module pkt_hdr_keep_mask
   import pkt_hdr_pkg::*;
(
   input  logic [KEEP_WIDTH-1:0]          i_keep,
   output logic [C_S_AXIS_DATA_WIDTH-1:0] o_mask,
   output logic [POPCNT_WIDTH-1:0]        o_count
);

   // replicate each keep bit across its byte lane and count enabled bytes
   always_comb begin
      // NOTE: every output gets a default before the loop so no path can leave it unassigned (no latch).
      o_mask  = '0;
      o_count = popcount32(i_keep);
      for (int b = 0; b < int'(KEEP_WIDTH); b++) begin
         o_mask[b*8 +: 8] = {8{i_keep[b]}};
      end
   end

endmodule

// File: rtl/pkt_hdr_capture.sv
// Snoops an AXI4-Stream and captures the first HDR_BEATS beats of every
// packet into a PHV (header + captured byte count), presented through a
// one-entry valid/ready holding register. A completed header that finds the
// register occupied and not being drained is dropped; the capture FSM keeps
// tracking packet boundaries regardless.
// Optional build macro: PKT_HDR_CAPTURE_STATS_EN adds accept/drop counters.
module pkt_hdr_capture
   import pkt_hdr_pkg::*;
(
   input  logic                           clk,
   input  logic                           reset,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [KEEP_WIDTH-1:0]          s_axis_tkeep,
   input  logic                           s_axis_tvalid,
   input  logic                           s_axis_tready,
   input  logic                           s_axis_tlast,
   output logic [PHV_WIDTH-1:0]           phv_out,
   output logic                           phv_valid,
   input  logic                           phv_ready
`ifdef PKT_HDR_CAPTURE_STATS_EN
   ,
   output logic [31:0]                    stat_pkt_cnt,
   output logic [31:0]                    stat_drop_cnt
`endif
);

   localparam int unsigned BEAT_IDX_W = (HDR_BEATS > 1) ? $clog2(HDR_BEATS) : 1;
   localparam logic [BEAT_IDX_W-1:0] LAST_IDX = BEAT_IDX_W'(HDR_BEATS - 1);

   cap_state_e                     r_state;
   cap_state_e                     w_state_nxt;
   logic [BEAT_IDX_W-1:0]          r_beat_cnt;
   logic [BEAT_IDX_W-1:0]          w_beat_cnt_nxt;
   logic [LEN_WIDTH-1:0]           r_byte_cnt;
   logic [HDR_WIDTH-1:0]           r_hdr_acc;

   logic                           w_beat;
   logic                           w_store;
   logic                           w_complete;
   logic                           w_load;
   logic [C_S_AXIS_DATA_WIDTH-1:0] w_keep_mask;
   logic [POPCNT_WIDTH-1:0]        w_keep_count;
   logic [HDR_WIDTH-1:0]           w_hdr_merged;
   logic [LEN_WIDTH-1:0]           w_byte_sum;

   logic                           r_phv_valid;
   logic [LEN_WIDTH-1:0]           r_phv_len;
   logic [HDR_WIDTH-1:0]           r_phv_hdr;

   assign w_beat = s_axis_tvalid && s_axis_tready;

   pkt_hdr_keep_mask u_keep_mask (
      .i_keep  (s_axis_tkeep),
      .o_mask  (w_keep_mask),
      .o_count (w_keep_count)
   );

   // capture FSM state register
   always_ff @(posedge clk) begin
      // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
      if (reset) begin
         r_state    <= IDLE;
         r_beat_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_beat_cnt <= w_beat_cnt_nxt;
      end
   end

   // next state, beat index and capture/complete strobes
   always_comb begin
      w_state_nxt    = r_state;
      w_beat_cnt_nxt = r_beat_cnt;
      w_store        = 1'b0;
      w_complete     = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_beat) begin
               w_store = 1'b1;
               if (s_axis_tlast || (HDR_BEATS == 1)) begin
                  w_complete     = 1'b1;
                  w_beat_cnt_nxt = '0;
                  w_state_nxt    = s_axis_tlast ? IDLE : SKIP;
               end else begin
                  w_beat_cnt_nxt = BEAT_IDX_W'(1);
                  w_state_nxt    = CAPTURE;
               end
            end
         end
         CAPTURE: begin
            if (w_beat) begin
               w_store = 1'b1;
               if (s_axis_tlast) begin
                  w_complete     = 1'b1;
                  w_beat_cnt_nxt = '0;
                  w_state_nxt    = IDLE;
               end else if (r_beat_cnt == LAST_IDX) begin
                  w_complete     = 1'b1;
                  w_beat_cnt_nxt = '0;
                  w_state_nxt    = SKIP;
               end else begin
                  w_beat_cnt_nxt = r_beat_cnt + 1'b1;
               end
            end
         end
         SKIP: begin
            if (w_beat && s_axis_tlast) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt    = IDLE;
            w_beat_cnt_nxt = '0;
         end
      endcase
   end

   // header and byte count including the current beat (beat index is 0 in IDLE)
   always_comb begin
      w_hdr_merged = r_hdr_acc;
      w_hdr_merged[r_beat_cnt*C_S_AXIS_DATA_WIDTH +: C_S_AXIS_DATA_WIDTH] =
         s_axis_tdata & w_keep_mask;
      w_byte_sum = r_byte_cnt + LEN_WIDTH'(w_keep_count);
   end

   // header accumulator: fills per beat, empties when a packet completes
   always_ff @(posedge clk) begin
      // NOTE: the accumulator is reset because unwritten header bytes must read as zero.
      if (reset) begin
         r_hdr_acc  <= '0;
         r_byte_cnt <= '0;
      end else if (w_complete) begin
         r_hdr_acc  <= '0;
         r_byte_cnt <= '0;
      end else if (w_store) begin
         r_hdr_acc  <= w_hdr_merged;
         r_byte_cnt <= w_byte_sum;
      end
   end

   // accept a completed header when the register is empty or draining this cycle
   assign w_load = w_complete && (!r_phv_valid || phv_ready);

   // one-entry PHV holding register with valid/ready handshake
   always_ff @(posedge clk) begin
      if (reset) begin
         r_phv_valid <= 1'b0;
         r_phv_len   <= '0;
         r_phv_hdr   <= '0;
      end else if (w_load) begin
         r_phv_valid <= 1'b1;
         r_phv_len   <= w_byte_sum;
         r_phv_hdr   <= w_hdr_merged;
      end else if (r_phv_valid && phv_ready) begin
         r_phv_valid <= 1'b0;
      end
   end

   assign phv_valid = r_phv_valid;
   assign phv_out   = {r_phv_hdr, r_phv_len, {RSVD_WIDTH{1'b0}}};

`ifdef PKT_HDR_CAPTURE_STATS_EN
   logic        w_drop;
   logic [31:0] r_stat_pkt_cnt;
   logic [31:0] r_stat_drop_cnt;

   assign w_drop = w_complete && r_phv_valid && !phv_ready;

   // free-running accept/drop counters, wrapping at 2^32
   always_ff @(posedge clk) begin
      if (reset) begin
         r_stat_pkt_cnt  <= '0;
         r_stat_drop_cnt <= '0;
      end else begin
         if (w_load) r_stat_pkt_cnt  <= r_stat_pkt_cnt + 32'd1;
         if (w_drop) r_stat_drop_cnt <= r_stat_drop_cnt + 32'd1;
      end
   end

   assign stat_pkt_cnt  = r_stat_pkt_cnt;
   assign stat_drop_cnt = r_stat_drop_cnt;
`endif

endmodule
